// File: rtl/onchip_dpram_ctrl.sv
// Dual-port on-chip RAM behind two Avalon-MM slaves: s1 read/write, s2 read-only.
// Adds a post-reset clear engine, pipelined read latency (1 or 2) and address range protection.
module onchip_dpram_ctrl #(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       ADDR_W         = 17,
  parameter int unsigned       DEPTH          = 100048,
  parameter int unsigned       READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_read,
  output logic                  s2_waitrequest,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  init_done,
  output logic                  range_err
);

  localparam int unsigned       BE_W      = DATA_W / 8;
  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic                busy, ready;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                clr_we;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                s1_in_range, s2_in_range;
  logic [IDX_W-1:0]    s1_idx, s2_idx, clr_idx;
  logic                s1_wr_acc, s1_rd_acc, s2_rd_acc;

  logic                s1_v0, s2_v0, s1_vl, s2_vl;
  logic [DATA_W-1:0]   s1_d0, s2_d0, s1_dl, s2_dl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    else if (clken) state_q <= state_d;
  end

  // Stall while reset is asserted too, so nothing is accepted in either state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    ready   = 1'b0;
    case (state_q)
      ST_CLEAR: if (clr_cnt_q == LAST_WORD) state_d = ST_READY;
      ST_READY: begin
        busy  = ~reset_n;
        ready = reset_n;
      end
      default: state_d = state_q;
    endcase
  end

  assign s1_waitrequest = busy;
  assign s2_waitrequest = busy;
  assign init_done      = ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              clr_cnt_q <= '0;
    else if (clken && (state_q == ST_CLEAR))   clr_cnt_q <= clr_cnt_q + 1'b1;
  end

  assign clr_we      = clken & reset_n & (state_q == ST_CLEAR);
  assign clr_idx     = clr_cnt_q[IDX_W-1:0];
  assign s1_in_range = {1'b0, s1_address} < DEPTH_X;
  assign s2_in_range = {1'b0, s2_address} < DEPTH_X;
  assign s1_idx      = s1_address[IDX_W-1:0];
  assign s2_idx      = s2_address[IDX_W-1:0];

  assign s1_wr_acc = clken & ~busy & s1_chipselect & s1_write;
  assign s1_rd_acc = clken & ~busy & s1_chipselect & s1_read & ~s1_write;
  assign s2_rd_acc = clken & ~busy & s2_read;

  // Reads sample the array before this edge's write lands, so s2 sees old data on a collision.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (clr_we) begin
        mem[clr_idx] <= CLEAR_VALUE;
      end else if (s1_wr_acc && s1_in_range) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
      end
      s1_d0 <= s1_in_range ? mem[s1_idx] : '0;
      s2_d0 <= s2_in_range ? mem[s2_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v0 <= 1'b0;
      s2_v0 <= 1'b0;
    end else if (clken) begin
      s1_v0 <= s1_rd_acc;
      s2_v0 <= s2_rd_acc;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              s1_v1, s2_v1;
    logic [DATA_W-1:0] s1_d1, s2_d1;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_v1 <= 1'b0;
        s2_v1 <= 1'b0;
      end else if (clken) begin
        s1_v1 <= s1_v0;
        s2_v1 <= s2_v0;
      end
    end

    always_ff @(posedge clk) begin
      if (clken) begin
        s1_d1 <= s1_d0;
        s2_d1 <= s2_d0;
      end
    end

    assign s1_vl = s1_v1;
    assign s2_vl = s2_v1;
    assign s1_dl = s1_d1;
    assign s2_dl = s2_d1;
  end else begin : g_lat1
    assign s1_vl = s1_v0;
    assign s2_vl = s2_v0;
    assign s1_dl = s1_d0;
    assign s2_dl = s2_d0;
  end

  // Read data only moves on a valid response; it holds the last value otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_readdatavalid <= 1'b0;
      s2_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
      s2_readdata      <= '0;
    end else if (clken) begin
      s1_readdatavalid <= s1_vl;
      s2_readdatavalid <= s2_vl;
      if (s1_vl) s1_readdata <= s1_dl;
      if (s2_vl) s2_readdata <= s2_dl;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_err <= 1'b0;
    end else if (((s1_wr_acc | s1_rd_acc) & ~s1_in_range) | (s2_rd_acc & ~s2_in_range)) begin
      range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_onchip_dpram_ctrl.sv
// Bench for onchip_dpram_ctrl: two instances (read latency 1 and 2) share one stimulus stream
// and are compared every cycle against an abstract memory/response-history model.
module tb_onchip_dpram_ctrl;

  localparam int          DW    = 16;
  localparam int          AW    = 5;
  localparam int          DEPTH = 16;
  localparam logic [15:0] CV    = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clken = 1'b1;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_read;
  logic [DW-1:0] s1_writedata;
  logic [1:0]    s1_byteenable;

  logic          s1_wait [2];
  logic          s2_wait [2];
  logic          s1_rv   [2];
  logic          s2_rv   [2];
  logic [DW-1:0] s1_rd   [2];
  logic [DW-1:0] s2_rd   [2];
  logic          idone   [2];
  logic          rerr    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    onchip_dpram_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(g + 1),
      .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .clken(clken),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
      .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
      .s1_waitrequest(s1_wait[g]), .s1_readdata(s1_rd[g]), .s1_readdatavalid(s1_rv[g]),
      .s2_address(s2_address), .s2_read(s2_read), .s2_waitrequest(s2_wait[g]),
      .s2_readdata(s2_rd[g]), .s2_readdatavalid(s2_rv[g]),
      .init_done(idone[g]), .range_err(rerr[g])
    );
  end

  // Reference model: word array, clear progress, and per-port history of accepted reads
  // keyed by the enabled-edge index at which they were accepted.
  logic [15:0] ref_mem [DEPTH];
  int          clr_edges;
  bit          ref_ready;
  bit          ref_rerr;
  int          en_cnt = 0;
  logic [15:0] h1 [int];
  logic [15:0] h2 [int];
  bit          exp_v1 [2];
  bit          exp_v2 [2];
  logic [15:0] exp_d1 [2];
  logic [15:0] exp_d2 [2];

  task automatic model_reset();
    clr_edges = 0;
    ref_ready = 1'b0;
    ref_rerr  = 1'b0;
    h1.delete();
    h2.delete();
    for (int k = 0; k < 2; k++) begin
      exp_v1[k] = 1'b0; exp_v2[k] = 1'b0;
      exp_d1[k] = '0;   exp_d2[k] = '0;
    end
  endtask

  task automatic model_edge();
    int a1, a2;
    if (!reset_n || !clken) return;
    en_cnt++;
    for (int k = 0; k < 2; k++) begin
      exp_v1[k] = h1.exists(en_cnt - (k + 1));
      exp_v2[k] = h2.exists(en_cnt - (k + 1));
      if (exp_v1[k]) exp_d1[k] = h1[en_cnt - (k + 1)];
      if (exp_v2[k]) exp_d2[k] = h2[en_cnt - (k + 1)];
    end
    if (!ref_ready) begin
      ref_mem[clr_edges] = CV;
      clr_edges++;
      if (clr_edges == DEPTH) ref_ready = 1'b1;
      return;
    end
    a1 = int'(s1_address);
    a2 = int'(s2_address);
    if (s2_read) begin
      if (a2 < DEPTH) h2[en_cnt] = ref_mem[a2];
      else begin h2[en_cnt] = '0; ref_rerr = 1'b1; end
    end
    if (s1_chipselect && s1_write) begin
      if (a1 < DEPTH) begin
        for (int b = 0; b < 2; b++)
          if (s1_byteenable[b]) ref_mem[a1][b*8 +: 8] = s1_writedata[b*8 +: 8];
      end else ref_rerr = 1'b1;
    end else if (s1_chipselect && s1_read) begin
      if (a1 < DEPTH) h1[en_cnt] = ref_mem[a1];
      else begin h1[en_cnt] = '0; ref_rerr = 1'b1; end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lat%0d.s1_waitrequest", k + 1), 32'(s1_wait[k]), 32'(!ref_ready));
      chk($sformatf("lat%0d.s2_waitrequest", k + 1), 32'(s2_wait[k]), 32'(!ref_ready));
      chk($sformatf("lat%0d.init_done", k + 1),      32'(idone[k]),   32'(ref_ready));
      chk($sformatf("lat%0d.range_err", k + 1),      32'(rerr[k]),    32'(ref_rerr));
      chk($sformatf("lat%0d.s1_readdatavalid", k + 1), 32'(s1_rv[k]), 32'(exp_v1[k]));
      chk($sformatf("lat%0d.s2_readdatavalid", k + 1), 32'(s2_rv[k]), 32'(exp_v2[k]));
      chk($sformatf("lat%0d.s1_readdata", k + 1),    32'(s1_rd[k]),   32'(exp_d1[k]));
      chk($sformatf("lat%0d.s2_readdata", k + 1),    32'(s2_rd[k]),   32'(exp_d2[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s2_read = 1'b0;
    s1_address = '0; s2_address = '0; s1_writedata = '0; s1_byteenable = 2'b11;
  endtask

  task automatic s1_wr(input int a, input logic [15:0] d, input logic [1:0] be);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0;
    s1_address = AW'(a); s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic s1_rdreq(input int a);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0; s1_address = AW'(a);
  endtask

  task automatic s2_rdreq(input int a);
    s2_read = 1'b1; s2_address = AW'(a);
  endtask

  task automatic drain();
    idle();
    repeat (3) cycle();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      s1_rdreq(i);
      s2_rdreq(DEPTH - 1 - i);
      cycle();
    end
    drain();
  endtask

  task automatic rand_req();
    s1_chipselect = ($urandom_range(3, 0) != 0);
    s1_read       = 1'($urandom);
    s1_write      = 1'($urandom);
    s1_address    = AW'($urandom_range(DEPTH + 1, 0));
    s1_writedata  = 16'($urandom);
    s1_byteenable = 2'($urandom);
    s2_read       = 1'($urandom);
    s2_address    = AW'($urandom_range(DEPTH + 1, 0));
  endtask

  task automatic clear_phase();
    for (int i = 0; i < DEPTH; i++) begin
      rand_req();
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;

    // Clear runs 16 enabled edges with requests ignored, then every word reads CLEAR_VALUE.
    clear_phase();
    cycle();
    read_all();

    // Byte lanes.
    s1_wr(3, 16'h1234, 2'b11); cycle();
    s1_wr(3, 16'hFFEE, 2'b01); cycle();
    idle(); s1_rdreq(3); cycle();
    drain();

    // Read and write strobes together count as a write only.
    s1_wr(4, 16'hBEEF, 2'b11); s1_read = 1'b1; cycle();
    drain();

    // Back-to-back reads on both ports.
    for (int i = 0; i < 8; i++) begin
      idle(); s1_rdreq(i); s2_rdreq(7 - i); cycle();
    end
    drain();

    // Cross-port collision.
    s1_wr(5, 16'h0001, 2'b11); cycle();
    s1_wr(5, 16'h0002, 2'b11); s2_rdreq(5); cycle();
    idle(); s2_rdreq(5); cycle();
    drain();

    // Out-of-range accesses.
    s1_wr(20, 16'h7777, 2'b11); cycle();
    idle(); s1_rdreq(20); cycle();
    idle(); s2_rdreq(17); cycle();
    drain();
    read_all();

    // Clock enable stall with reads in flight.
    s1_rdreq(1); s2_rdreq(2); cycle();
    s1_rdreq(2); s2_rdreq(3); cycle();
    idle(); clken = 1'b0;
    repeat (3) cycle();
    clken = 1'b1;
    drain();

    // Randomised traffic with sporadic clock-enable drops.
    repeat (300) begin
      clken = ($urandom_range(9, 0) != 0);
      rand_req();
      cycle();
    end
    clken = 1'b1;
    drain();

    // Reset with reads in flight, then reset again partway through the clear.
    s1_rdreq(3); s2_rdreq(4); cycle();
    idle(); s1_rdreq(5); cycle();
    idle();
    reset_n = 1'b0; model_reset(); #1; check_all();
    cycle(); cycle();
    reset_n = 1'b1;
    repeat (7) cycle();
    reset_n = 1'b0; model_reset(); #1; check_all();
    cycle();
    reset_n = 1'b1;
    clear_phase();
    cycle();
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
